hilo_result_unit: RTL and testbench
===================================

Name: hilo_result_unit

Overview:
- Parametrised successor to the 2:1 div/mult result select.
- Owns the HI/LO architectural registers of the multi-cycle MIPS core.
- Selects one of N_SRC long-latency arithmetic units, waits on its done handshake, commits the 64-bit result into HI/LO, and stalls mfhi/mflo reads while a result is pending.
- Also serves mthi/mtlo direct writes, flags divide errors, and flags timeouts.

Parameters:
- DATA_W, 32: width of HI, LO and each source half.
- N_SRC, 2: number of result sources (index 0 = div, 1 = mult).
- SEL_W, 1: select width; must be ≥ 1 and satisfy 2**SEL_W ≥ N_SRC.
- TIMEOUT_W, 6: wait-counter width; timeout after 2**TIMEOUT_W-1 wait cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: begin waiting on src_sel.
- src_sel  in  SEL_W  source index, sampled only on an accepted start.
- src_hi  in  N_SRC*DATA_W  packed HI halves; source i at bits [i*DATA_W +: DATA_W].
- src_lo  in  N_SRC*DATA_W  packed LO halves, same packing.
- src_done  in  N_SRC  per-source done; may be held high.
- src_err  in  N_SRC  per-source error (e.g. div by zero); valid only with done.
- wr_hi  in  1  mthi write strobe.
- wr_lo  in  1  mtlo write strobe.
- wr_data  in  DATA_W  mthi/mtlo data.
- rd_req  in  1  mfhi/mflo in progress.
- hi_out  out  DATA_W  HI register.
- lo_out  out  DATA_W  LO register.
- busy  out  1  result pending (state WAIT).
- stall  out  1  busy & rd_req (modified by the optional feature below).
- err  out  1  sticky error flag.

Behaviour:
- Reset (async, any state): hi_out = 0, lo_out = 0, err = 0, state = IDLE, sel_q = 0, wait counter = 0; busy and stall therefore 0.
- FSM states: IDLE, WAIT.
- IDLE + start, src_sel < N_SRC:
  - sel_q <= src_sel, counter <= 0, err <= 0, go to WAIT.
  - busy is high from the next cycle.
- IDLE + start, src_sel ≥ N_SRC: err <= 1, stay in IDLE, HI/LO unchanged.
- WAIT + src_done[sel_q] = 1:
  - If src_err[sel_q] = 0: HI <= src_hi[sel_q], LO <= src_lo[sel_q].
  - If src_err[sel_q] = 1: err <= 1, HI/LO unchanged.
  - Either way, go to IDLE.
  - Commit latency: the edge on which done is sampled updates HI/LO and drops busy.
- WAIT + no done:
  - counter increments each cycle.
  - When counter reaches all-ones with no done: err <= 1, go to IDLE, HI/LO unchanged.
- Done on a source other than sel_q is ignored in all states.
- start while in WAIT is ignored; no queueing.
- wr_hi / wr_lo:
  - Honoured only in IDLE, on the next edge; both strobes may be asserted together.
  - Ignored in WAIT; the pending result owns HI/LO.
  - Same cycle as an accepted start: the write takes effect and start is also accepted.
- stall is combinational: busy & rd_req.
- Reset asserted mid-WAIT aborts the operation; a later src_done is ignored.

Optional Feature:
- Macro: HILO_FWD_EN.
- When defined:
  - hi_out/lo_out are combinationally bypassed to src_hi/src_lo[sel_q] in the WAIT cycle where src_done[sel_q] = 1 and src_err[sel_q] = 0.
  - stall is deasserted in that same cycle, saving one stall cycle per mfhi/mflo.
- When undefined: outputs come from the registers only, and stall = busy & rd_req.

Decomposition:
- Package hilo_pkg:
  - state enum (IDLE, WAIT);
  - source index constants SRC_DIV = 0, SRC_MULT = 1;
  - default DATA_W.
- Sub-module hilo_src_mux: combinational N_SRC:1 selector of {hi, lo, done, err} indexed by sel_q. It is the direct generalisation of the 2:1 div/mult mux.

Test Plan:
- Mult result: start, src_sel = 1; src_done[1] asserted 3 cycles later with src_hi = 32'h0000_0001, src_lo = 32'hFFFF_0000 → busy high for 3 cycles; HI/LO = 1 / FFFF0000 after the done edge; err = 0.
- Div by zero: start, src_sel = 0; src_done[0] = 1 with src_err[0] = 1 → err = 1; HI/LO keep their prior values 5 / 7; next start clears err.
- Timeout: TIMEOUT_W = 3, start with no done → err = 1 and busy low after 7 wait cycles; a late src_done is ignored.
- mthi during WAIT: wr_hi with wr_data = 32'hDEAD_BEEF → HI unchanged. In IDLE, simultaneous wr_hi and wr_lo with 32'h1234 → HI = LO = 1234.
- Stall: rd_req held through a 4-cycle WAIT → stall high 4 cycles; with HILO_FWD_EN, stall high 3 cycles and hi_out equals src_hi in the done cycle.
- Reset mid-WAIT, then src_done[0] → HI = LO = 0, busy = 0, err = 0; src_sel = 2 with N_SRC = 2 → err = 1, stays in IDLE.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO result unit.
package hilo_pkg;

    // Default width of HI, LO and each source half.
    localparam int HILO_DATA_W = 32;

    // Source indices for the two long-latency units of the baseline core.
    localparam int SRC_DIV  = 0;
    localparam int SRC_MULT = 1;

    // Result-wait state machine encoding.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } hilo_state_e;

endpackage

// File: rtl/hilo_result_unit_if.sv
// Bus bundle between the core pipeline (master) and the HI/LO result unit (slave).
interface hilo_result_unit_if
    import hilo_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W,
    parameter int N_SRC  = 2,
    parameter int SEL_W  = 1
);
    logic                      start;
    logic [SEL_W-1:0]          src_sel;
    logic [N_SRC*DATA_W-1:0]   src_hi;
    logic [N_SRC*DATA_W-1:0]   src_lo;
    logic [N_SRC-1:0]          src_done;
    logic [N_SRC-1:0]          src_err;
    logic                      wr_hi;
    logic                      wr_lo;
    logic [DATA_W-1:0]         wr_data;
    logic                      rd_req;
    logic [DATA_W-1:0]         hi_out;
    logic [DATA_W-1:0]         lo_out;
    logic                      busy;
    logic                      stall;
    logic                      err;

    modport master (
        output start, src_sel, src_hi, src_lo, src_done, src_err,
        output wr_hi, wr_lo, wr_data, rd_req,
        input  hi_out, lo_out, busy, stall, err
    );

    modport slave (
        input  start, src_sel, src_hi, src_lo, src_done, src_err,
        input  wr_hi, wr_lo, wr_data, rd_req,
        output hi_out, lo_out, busy, stall, err
    );
endinterface

// File: rtl/hilo_src_mux.sv
// N_SRC:1 selector of {hi, lo, done, err}; generalises the old div/mult 2:1 mux.
module hilo_src_mux #(
    parameter int DATA_W = 32,
    parameter int N_SRC  = 2,
    parameter int SEL_W  = 1
) (
    input  logic [SEL_W-1:0]        sel,
    input  logic [N_SRC*DATA_W-1:0] src_hi,
    input  logic [N_SRC*DATA_W-1:0] src_lo,
    input  logic [N_SRC-1:0]        src_done,
    input  logic [N_SRC-1:0]        src_err,
    output logic [DATA_W-1:0]       hi,
    output logic [DATA_W-1:0]       lo,
    output logic                    done,
    output logic                    err
);

    // AND-OR select: an out-of-range index yields all zeros, never X.
    always_comb begin
        hi   = {DATA_W{1'b0}};
        lo   = {DATA_W{1'b0}};
        done = 1'b0;
        err  = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            hi   = hi   | ({DATA_W{sel == SEL_W'(i)}} & src_hi[i*DATA_W +: DATA_W]);
            lo   = lo   | ({DATA_W{sel == SEL_W'(i)}} & src_lo[i*DATA_W +: DATA_W]);
            done = done | ((sel == SEL_W'(i)) & src_done[i]);
            err  = err  | ((sel == SEL_W'(i)) & src_err[i]);
        end
    end

endmodule

// File: rtl/hilo_result_unit.sv
// HI/LO architectural registers with multi-source result commit, mthi/mtlo
// writes, sticky error and wait timeout.
// Optional build macro HILO_FWD_EN: forwards the committing result onto
// hi_out/lo_out and drops stall in the done cycle.
module hilo_result_unit
    import hilo_pkg::*;
#(
    parameter int DATA_W    = HILO_DATA_W,
    parameter int N_SRC     = 2,
    parameter int SEL_W     = 1,
    parameter int TIMEOUT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    hilo_result_unit_if.slave bus
);

    localparam logic [SEL_W:0] N_SRC_L = (SEL_W+1)'(N_SRC);

    hilo_state_e            state_r;
    hilo_state_e            state_next_s;
    logic [SEL_W-1:0]       sel_r;
    logic [TIMEOUT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]      hi_r;
    logic [DATA_W-1:0]      lo_r;
    logic                   err_r;

    logic [DATA_W-1:0]      mux_hi_s;
    logic [DATA_W-1:0]      mux_lo_s;
    logic                   mux_done_s;
    logic                   mux_err_s;

    logic                   sel_ok_s;
    logic                   start_ok_s;
    logic                   timeout_s;
    logic                   commit_s;
    logic                   err_set_s;
    logic                   err_clr_s;
    logic                   cnt_inc_s;
    logic                   wr_en_s;

    hilo_src_mux #(
        .DATA_W (DATA_W),
        .N_SRC  (N_SRC),
        .SEL_W  (SEL_W)
    ) u_src_mux (
        .sel      (sel_r),
        .src_hi   (bus.src_hi),
        .src_lo   (bus.src_lo),
        .src_done (bus.src_done),
        .src_err  (bus.src_err),
        .hi       (mux_hi_s),
        .lo       (mux_lo_s),
        .done     (mux_done_s),
        .err      (mux_err_s)
    );

    assign sel_ok_s   = ({1'b0, bus.src_sel} < N_SRC_L);
    assign start_ok_s = bus.start & sel_ok_s & (state_r == IDLE);
    // Timeout fires on the edge that would bring the counter to all-ones.
    assign timeout_s  = &(cnt_r + TIMEOUT_W'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: leave WAIT on the selected done or on timeout.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (mux_done_s || timeout_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM control outputs driving the datapath registers.
    always_comb begin
        commit_s  = 1'b0;
        err_set_s = 1'b0;
        err_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        wr_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                wr_en_s   = 1'b1;
                err_clr_s = start_ok_s;
                err_set_s = bus.start & ~sel_ok_s;
            end
            WAIT: begin
                if (mux_done_s) begin
                    commit_s  = ~mux_err_s;
                    err_set_s = mux_err_s;
                end else begin
                    cnt_inc_s = 1'b1;
                    err_set_s = timeout_s;
                end
            end
            default: begin
                commit_s = 1'b0;
            end
        endcase
    end

    // HI/LO, error flag, source select and wait counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r  <= {DATA_W{1'b0}};
            lo_r  <= {DATA_W{1'b0}};
            err_r <= 1'b0;
            sel_r <= {SEL_W{1'b0}};
            cnt_r <= {TIMEOUT_W{1'b0}};
        end else begin
            if (commit_s) begin
                hi_r <= mux_hi_s;
                lo_r <= mux_lo_s;
            end else begin
                if (wr_en_s && bus.wr_hi) begin
                    hi_r <= bus.wr_data;
                end
                if (wr_en_s && bus.wr_lo) begin
                    lo_r <= bus.wr_data;
                end
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr_s) begin
                err_r <= 1'b0;
            end
            if (start_ok_s) begin
                sel_r <= bus.src_sel;
                cnt_r <= {TIMEOUT_W{1'b0}};
            end else if (cnt_inc_s) begin
                cnt_r <= cnt_r + TIMEOUT_W'(1);
            end
        end
    end

    assign bus.busy = (state_r == WAIT);
    assign bus.err  = err_r;

`ifdef HILO_FWD_EN
    logic fwd_s;
    assign fwd_s      = (state_r == WAIT) & mux_done_s & ~mux_err_s;
    assign bus.hi_out = fwd_s ? mux_hi_s : hi_r;
    assign bus.lo_out = fwd_s ? mux_lo_s : lo_r;
    assign bus.stall  = bus.busy & bus.rd_req & ~fwd_s;
`else
    assign bus.hi_out = hi_r;
    assign bus.lo_out = lo_r;
    assign bus.stall  = bus.busy & bus.rd_req;
`endif

endmodule

// File: tb/tb_hilo_result_unit.sv
// Directed self-checking bench for hilo_result_unit (N_SRC=2, SEL_W=2, TIMEOUT_W=3).
module tb_hilo_result_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   busy_n;
    int   stall_n;

    always #5 clk = ~clk;

    hilo_result_unit_if #(.DATA_W(32), .N_SRC(2), .SEL_W(2)) bus ();

    hilo_result_unit #(
        .DATA_W    (32),
        .N_SRC     (2),
        .SEL_W     (2),
        .TIMEOUT_W (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.src_sel  = 2'd0;
        bus.src_hi   = 64'h0;
        bus.src_lo   = 64'h0;
        bus.src_done = 2'b00;
        bus.src_err  = 2'b00;
        bus.wr_hi    = 1'b0;
        bus.wr_lo    = 1'b0;
        bus.wr_data  = 32'h0;
        bus.rd_req   = 1'b0;
        #12;
        check_eq("rst_hi", bus.hi_out, 32'h0);
        check_eq("rst_lo", bus.lo_out, 32'h0);
        check_eq("rst_err", bus.err, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_stall", bus.stall, 1'b0);
        cyc();
        reset = 1'b0;

        // Preload HI=5, LO=7 via mthi/mtlo.
        bus.wr_hi = 1'b1; bus.wr_data = 32'h5; cyc();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'h7; cyc();
        bus.wr_lo = 1'b0; smp();
        check_eq("pre_hi", bus.hi_out, 32'h5);
        check_eq("pre_lo", bus.lo_out, 32'h7);

        // Divide by zero: error set, HI/LO preserved.
        bus.start = 1'b1; bus.src_sel = 2'd0; cyc();
        bus.start = 1'b0; bus.src_done = 2'b01; bus.src_err = 2'b01; smp();
        check_eq("dz_busy", bus.busy, 1'b1);
        cyc();
        bus.src_done = 2'b00; bus.src_err = 2'b00; smp();
        check_eq("dz_err", bus.err, 1'b1);
        check_eq("dz_hi", bus.hi_out, 32'h5);
        check_eq("dz_lo", bus.lo_out, 32'h7);
        check_eq("dz_busy_lo", bus.busy, 1'b0);

        // Mult result, done in the third wait cycle; start clears err.
        bus.src_hi = {32'h0000_0001, 32'h1111_1111};
        bus.src_lo = {32'hFFFF_0000, 32'h2222_2222};
        bus.start = 1'b1; bus.src_sel = 2'd1; cyc();
        bus.start = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.src_done = 2'b10;
            smp();
            if (k == 0) check_eq("mul_err_clr", bus.err, 1'b0);
            if (bus.busy === 1'b1) busy_n++;
            cyc();
        end
        bus.src_done = 2'b00; smp();
        check_eq("mul_busy_cycles", busy_n, 3);
        check_eq("mul_busy_lo", bus.busy, 1'b0);
        check_eq("mul_hi", bus.hi_out, 32'h0000_0001);
        check_eq("mul_lo", bus.lo_out, 32'hFFFF_0000);
        check_eq("mul_err", bus.err, 1'b0);

        // Timeout after 7 wait cycles, late done ignored.
        bus.start = 1'b1; bus.src_sel = 2'd0; cyc();
        bus.start = 1'b0;
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (bus.busy !== 1'b1) break;
            busy_n++;
            cyc();
        end
        check_eq("to_cycles", busy_n, 7);
        check_eq("to_err", bus.err, 1'b1);
        check_eq("to_hi", bus.hi_out, 32'h0000_0001);
        bus.src_hi = {32'h0000_0001, 32'hCAFE_0000};
        bus.src_done = 2'b01; cyc();
        bus.src_done = 2'b00; smp();
        check_eq("to_late_hi", bus.hi_out, 32'h0000_0001);
        check_eq("to_late_busy", bus.busy, 1'b0);

        // mthi together with accepted start, then mthi during WAIT ignored.
        bus.start = 1'b1; bus.src_sel = 2'd1; bus.wr_hi = 1'b1; bus.wr_data = 32'h55; cyc();
        bus.start = 1'b0; bus.wr_data = 32'hDEAD_BEEF; smp();
        check_eq("ws_hi", bus.hi_out, 32'h55);
        check_eq("ws_busy", bus.busy, 1'b1);
        check_eq("ws_err_clr", bus.err, 1'b0);
        cyc();
        bus.wr_hi = 1'b0; smp();
        check_eq("wait_wr_hi", bus.hi_out, 32'h55);
        bus.src_hi = {32'hA5A5_A5A5, 32'hCAFE_0000};
        bus.src_lo = {32'h5A5A_5A5A, 32'h0000_0000};
        bus.src_done = 2'b10; cyc();
        bus.src_done = 2'b00; smp();
        check_eq("c2_hi", bus.hi_out, 32'hA5A5_A5A5);
        check_eq("c2_lo", bus.lo_out, 32'h5A5A_5A5A);
        bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h1234; cyc();
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; smp();
        check_eq("dual_hi", bus.hi_out, 32'h1234);
        check_eq("dual_lo", bus.lo_out, 32'h1234);

        // Stall across a 4-cycle WAIT; done on the unselected source ignored.
        bus.src_hi = {32'hA5A5_A5A5, 32'h0BAD_F00D};
        bus.src_lo = {32'h5A5A_5A5A, 32'h600D_CAFE};
        bus.rd_req = 1'b1;
        bus.start = 1'b1; bus.src_sel = 2'd0; cyc();
        bus.start = 1'b0; bus.src_done = 2'b10;
        stall_n = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) bus.src_done = 2'b11;
            smp();
            if (bus.stall === 1'b1) stall_n++;
            if (k == 3) begin
`ifdef HILO_FWD_EN
                check_eq("st_fwd_hi", bus.hi_out, 32'h0BAD_F00D);
                check_eq("st_fwd_lo", bus.lo_out, 32'h600D_CAFE);
`else
                check_eq("st_reg_hi", bus.hi_out, 32'h1234);
                check_eq("st_reg_lo", bus.lo_out, 32'h1234);
`endif
            end
            cyc();
        end
        bus.src_done = 2'b00; smp();
`ifdef HILO_FWD_EN
        check_eq("st_cycles", stall_n, 3);
`else
        check_eq("st_cycles", stall_n, 4);
`endif
        check_eq("st_after", bus.stall, 1'b0);
        check_eq("st_hi", bus.hi_out, 32'h0BAD_F00D);
        check_eq("st_lo", bus.lo_out, 32'h600D_CAFE);
        bus.rd_req = 1'b0;

        // Reset mid-WAIT, then a stale done is ignored.
        bus.start = 1'b1; bus.src_sel = 2'd0; cyc();
        bus.start = 1'b0; smp();
        check_eq("rw_busy", bus.busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        check_eq("rw_hi", bus.hi_out, 32'h0);
        check_eq("rw_lo", bus.lo_out, 32'h0);
        check_eq("rw_busy_lo", bus.busy, 1'b0);
        check_eq("rw_err", bus.err, 1'b0);
        reset = 1'b0;
        bus.src_done = 2'b01; cyc();
        bus.src_done = 2'b00; smp();
        check_eq("rw_stale_hi", bus.hi_out, 32'h0);
        check_eq("rw_stale_busy", bus.busy, 1'b0);

        // Out-of-range source index.
        bus.start = 1'b1; bus.src_sel = 2'd2; cyc();
        bus.start = 1'b0; smp();
        check_eq("bad_sel_err", bus.err, 1'b1);
        check_eq("bad_sel_busy", bus.busy, 1'b0);
        check_eq("bad_sel_hi", bus.hi_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
